// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the KLP32 pipeline control: stage slot record, bypass select
// encoding, controller state, and the slot-vs-source match helper.
package pipe_ctrl_pkg;

  localparam int RA_W = 5;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] rd;
    logic            we;
    logic            is_load;
    logic            is_mc;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
  } stage_slot_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_M  = 2'b01,
    FWD_W  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } hz_state_e;

  // x0 is hardwired zero, so it never produces a bypass
  function automatic logic slot_hit(input stage_slot_t s, input logic [RA_W-1:0] src);
    return s.valid & s.we & (s.rd != '0) & (s.rd == src);
  endfunction

endpackage

// File: rtl/fwd_compare.sv
// Bypass select for one X operand: the younger M result wins over W.
module fwd_compare
  import pipe_ctrl_pkg::*;
(
  input  logic            en,
  input  logic [RA_W-1:0] src,
  input  stage_slot_t     m_slot,
  input  stage_slot_t     w_slot,
  output fwd_sel_e        sel
);

  always_comb begin
    sel = FWD_RF;
    if (en) begin
      if (slot_hit(m_slot, src))      sel = FWD_M;
      else if (slot_hit(w_slot, src)) sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// KLP32 stall/flush/forward controller: X/M/W destination slots, load-use
// bubbles, taken-branch flush and multicycle op sequencing with a watchdog.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW        = RA_W,
  parameter int MC_MAX_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              id_is_mc,
  input  logic              x_branch_taken,
  input  logic              mc_done,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idx_flush,
  output logic              mc_start,
  output logic              mc_err,
  output logic [1:0]        a_sel_mux,
  output logic [1:0]        b_sel_mux,
  output logic              data_sel_mux
);

  localparam int CW = $clog2(MC_MAX_CYCLES + 1);

  stage_slot_t   x_q, m_q, w_q, id_slot;
  hz_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          mc_err_q;
  logic          branch, hold, load_use, timeout;

  always_comb begin
    id_slot = '0;
    if (id_valid) begin
      id_slot.valid   = 1'b1;
      id_slot.rd      = id_rd;
      id_slot.we      = id_reg_write;
      id_slot.is_load = id_is_load;
      id_slot.is_mc   = id_is_mc;
      id_slot.rs1     = id_rs1;
      id_slot.rs2     = id_rs2;
    end
  end

  // hold = multicycle op keeps X; covers the start cycle and every wait cycle
  always_comb begin
    state_d  = state_q;
    branch   = 1'b0;
    mc_start = 1'b0;
    hold     = 1'b0;
    load_use = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      RUN: begin
        branch   = x_q.valid & x_branch_taken;
        mc_start = x_q.valid & x_q.is_mc & ~branch;
        hold     = mc_start & ~mc_done;
        load_use = ~branch & ~hold & x_q.valid & x_q.is_load & (x_q.rd != '0) & id_valid &
                   ((id_rs1_used & (id_rs1 == x_q.rd)) | (id_rs2_used & (id_rs2 == x_q.rd)));
        if (hold) state_d = MC_WAIT;
      end
      MC_WAIT: begin
        timeout = (cnt_q == CW'(MC_MAX_CYCLES));
        hold    = ~mc_done & ~timeout;
        if (!hold) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q      <= '0;
      m_q      <= '0;
      w_q      <= '0;
      state_q  <= RUN;
      cnt_q    <= '0;
      mc_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= m_q;
      if (hold) begin
        m_q <= '0;
      end else begin
        m_q <= x_q;
        x_q <= (branch | load_use) ? stage_slot_t'('0) : id_slot;
      end
      cnt_q <= (state_q == MC_WAIT && hold) ? cnt_q + 1'b1 : '0;
      if (timeout) mc_err_q <= 1'b1;
    end
  end

  assign pc_stall   = hold | load_use;
  assign ifid_stall = hold | load_use;
  assign ifid_flush = branch;
  assign idx_flush  = branch | load_use;
  assign mc_err     = mc_err_q;

  logic     [1:0][REG_AW-1:0] op_src;
  fwd_sel_e [1:0]             op_sel;

  assign op_src = {x_q.rs2, x_q.rs1};

  for (genvar i = 0; i < 2; i++) begin : g_op
    fwd_compare u_fwd (
      .en     (x_q.valid),
      .src    (op_src[i]),
      .m_slot (m_q),
      .w_slot (w_q),
      .sel    (op_sel[i])
    );
  end

  assign a_sel_mux    = op_sel[0];
  assign b_sel_mux    = op_sel[1];
  assign data_sel_mux = m_q.valid & slot_hit(w_q, m_q.rs2);

  // W only ever sources a bypass; its remaining fields are carried for uniformity
  logic unused_w;
  assign unused_w = ^{w_q.is_load, w_q.is_mc, w_q.rs1, w_q.rs2};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios plus random
// instruction streams, checked against an instruction-level pipeline model.
module tb_pipeline_hazard_ctrl;

  localparam int MAXC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_is_mc;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       x_branch_taken, mc_done;
  logic       pc_stall, ifid_stall, ifid_flush, idx_flush, mc_start, mc_err, data_sel_mux;
  logic [1:0] a_sel_mux, b_sel_mux;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(5), .MC_MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mc(id_is_mc),
    .x_branch_taken(x_branch_taken), .mc_done(mc_done), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idx_flush(idx_flush),
    .mc_start(mc_start), .mc_err(mc_err), .a_sel_mux(a_sel_mux), .b_sel_mux(b_sel_mux),
    .data_sel_mux(data_sel_mux)
  );

  // model: one record per in-flight instruction
  typedef struct {bit v; bit we; bit ld; bit mc; int rd; int rs1; int rs2;} ins_t;

  ins_t px, pm, pw;
  bit   waiting, err;
  int   waited;
  bit   e_brn, e_start, e_tmo, e_hold, e_lu;
  int   n_err = 0, n_chk = 0;
  int   starts, stalls;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t bub();
    ins_t b;
    b = '{default: 0};
    return b;
  endfunction

  function automatic bit hit(ins_t s, int src);
    return s.v && s.we && s.rd != 0 && s.rd == src;
  endfunction

  function automatic int fsel(ins_t x, ins_t m, ins_t w, int src);
    if (!x.v) return 0;
    if (hit(m, src)) return 1;
    if (hit(w, src)) return 2;
    return 0;
  endfunction

  task automatic set_id(bit v, int rd, bit we, bit ld, bit mc, int rs1, bit u1, int rs2, bit u2);
    id_valid = v; id_rd = 5'(rd); id_reg_write = we; id_is_load = ld; id_is_mc = mc;
    id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
  endtask

  task automatic nop();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // called at negedge with inputs applied; checks every output against the model
  task automatic eval(input string tag);
    bit dep;
    #1;
    e_brn   = !waiting && px.v && x_branch_taken;
    e_start = !waiting && px.v && px.mc && !e_brn;
    e_tmo   = waiting && waited == MAXC;
    e_hold  = (e_start && !mc_done) || (waiting && !mc_done && !e_tmo);
    dep     = (id_rs1_used && id_rs1 == px.rd) || (id_rs2_used && id_rs2 == px.rd);
    e_lu    = !waiting && !e_brn && !e_hold && px.v && px.ld && px.rd != 0 && id_valid && dep;
    chk({tag, ".pc_stall"},   32'(pc_stall),     32'(e_hold || e_lu));
    chk({tag, ".ifid_stall"}, 32'(ifid_stall),   32'(e_hold || e_lu));
    chk({tag, ".ifid_flush"}, 32'(ifid_flush),   32'(e_brn));
    chk({tag, ".idx_flush"},  32'(idx_flush),    32'(e_brn || e_lu));
    chk({tag, ".mc_start"},   32'(mc_start),     32'(e_start));
    chk({tag, ".mc_err"},     32'(mc_err),       32'(err));
    chk({tag, ".a_sel"},      32'(a_sel_mux),    32'(fsel(px, pm, pw, px.rs1)));
    chk({tag, ".b_sel"},      32'(b_sel_mux),    32'(fsel(px, pm, pw, px.rs2)));
    chk({tag, ".data_sel"},   32'(data_sel_mux), 32'(pm.v && hit(pw, pm.rs2)));
  endtask

  task automatic adv();
    ins_t idi;
    idi = bub();
    if (id_valid) begin
      idi.v = 1; idi.we = id_reg_write; idi.ld = id_is_load; idi.mc = id_is_mc;
      idi.rd = int'(id_rd); idi.rs1 = int'(id_rs1); idi.rs2 = int'(id_rs2);
    end
    pw = pm;
    if (e_hold) pm = bub();
    else begin
      pm = px;
      px = (e_brn || e_lu) ? bub() : idi;
    end
    if (waiting) begin
      if (mc_done || e_tmo) waiting = 0;
      else waited++;
    end else if (e_start && !mc_done) begin
      waiting = 1;
      waited  = 0;
    end
    if (e_tmo) err = 1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.pc_stall",   32'(pc_stall),     0);
    chk("rst.ifid_stall", 32'(ifid_stall),   0);
    chk("rst.ifid_flush", 32'(ifid_flush),   0);
    chk("rst.idx_flush",  32'(idx_flush),    0);
    chk("rst.mc_start",   32'(mc_start),     0);
    chk("rst.mc_err",     32'(mc_err),       0);
    chk("rst.a_sel",      32'(a_sel_mux),    0);
    chk("rst.b_sel",      32'(b_sel_mux),    0);
    chk("rst.data_sel",   32'(data_sel_mux), 0);
    px = bub(); pm = bub(); pw = bub();
    waiting = 0; waited = 0; err = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    nop();
    x_branch_taken = 1'b0;
    mc_done        = 1'b0;
    @(negedge clk);
    do_reset();

    // forwarding: M and W both match, then only W, then rd=0
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 0); eval("f1"); adv();
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 0); eval("f2"); adv();
    set_id(1, 7, 1, 0, 0, 4, 1, 4, 1); eval("f3"); adv();
    nop(); eval("f4"); chk("fwd_m", 32'(a_sel_mux), 1); adv();
    set_id(1, 4, 1, 0, 0, 0, 0, 0, 0); eval("f5"); adv();
    nop(); eval("f6"); adv();
    set_id(1, 7, 1, 0, 0, 4, 1, 0, 0); eval("f7"); adv();
    nop(); eval("f8"); chk("fwd_w", 32'(a_sel_mux), 2); adv();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0); eval("f9"); adv();
    set_id(1, 0, 1, 0, 0, 0, 0, 0, 0); eval("f10"); adv();
    set_id(1, 7, 1, 0, 0, 0, 1, 0, 0); eval("f11"); adv();
    nop(); eval("f12"); chk("fwd_rd0", 32'(a_sel_mux), 0); adv();

    // load-use: one stall cycle, dependent op later bypasses from W
    set_id(1, 5, 1, 1, 0, 0, 0, 0, 0); eval("l1"); adv();
    set_id(1, 6, 1, 0, 0, 1, 1, 5, 1); eval("l2");
    chk("lu_stall", 32'(pc_stall), 1); chk("lu_bubble", 32'(idx_flush), 1); adv();
    eval("l3"); chk("lu_once", 32'(pc_stall), 0); adv();
    nop(); eval("l4"); chk("lu_bsel", 32'(b_sel_mux), 2); adv();

    // taken branch coincident with a load-use: flush only
    set_id(1, 5, 1, 1, 0, 0, 0, 0, 0); eval("b0"); adv();
    set_id(1, 6, 1, 0, 0, 5, 1, 0, 0); x_branch_taken = 1'b1; eval("b1");
    chk("br_flush", 32'(ifid_flush), 1); chk("br_idx", 32'(idx_flush), 1);
    chk("br_nostall", 32'(pc_stall), 0); adv();
    x_branch_taken = 1'b0; nop(); eval("b2"); chk("br_after", 32'(pc_stall), 0); adv();

    // multicycle op, done three cycles after start
    set_id(1, 8, 1, 0, 1, 1, 1, 2, 1); eval("m0"); adv();
    starts = 0; stalls = 0;
    for (int i = 0; i < 6; i++) begin
      mc_done = (i == 3);
      if (i <= 3) set_id(1, 9, 1, 0, 0, 8, 1, 0, 0); else nop();
      eval("mc");
      starts += int'(mc_start); stalls += int'(pc_stall);
      adv();
    end
    mc_done = 1'b0;
    chk("mc_starts", 32'(starts), 1);
    chk("mc_stalls", 32'(stalls), 3);

    // done in the start cycle: no wait at all
    set_id(1, 8, 1, 0, 1, 1, 1, 2, 1); eval("mz0"); adv();
    nop(); mc_done = 1'b1; eval("mz1");
    chk("mc_zero_start", 32'(mc_start), 1); chk("mc_zero_stall", 32'(pc_stall), 0); adv();
    mc_done = 1'b0; eval("mz2"); chk("mc_zero_after", 32'(pc_stall), 0); adv();

    // reset mid MC_WAIT, then a fresh instruction must not stall
    set_id(1, 8, 1, 0, 1, 0, 0, 0, 0); eval("r0"); adv();
    nop(); eval("r1"); adv();
    eval("r2"); adv();
    do_reset();
    set_id(1, 3, 1, 0, 0, 5, 1, 5, 1); eval("r3");
    chk("rst_first", 32'(pc_stall), 0); chk("rst_no_start", 32'(mc_start), 0); adv();

    // watchdog: no mc_done ever
    set_id(1, 8, 1, 0, 1, 0, 0, 0, 0); eval("w0"); adv();
    nop(); stalls = 0;
    for (int i = 0; i < 6; i++) begin
      eval("wd"); stalls += int'(pc_stall); adv();
    end
    chk("wd_stalls", 32'(stalls), 5);
    eval("wd_e"); chk("wd_err", 32'(mc_err), 1); chk("wd_run", 32'(pc_stall), 0); adv();
    for (int i = 0; i < 3; i++) begin
      mc_done = 1'(i & 1); eval("wd_s"); adv();
    end
    mc_done = 1'b0;
    chk("wd_sticky", 32'(mc_err), 1);
    do_reset();

    // random instruction streams
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        int k;
        k = int'($urandom_range(0, 7));
        set_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
               k < 2, k == 2, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        x_branch_taken = ($urandom_range(0, 5) == 0);
        mc_done        = ($urandom_range(0, 3) == 0);
        eval("rnd");
        adv();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
